// File: rtl/sr_dmem_ctrl_pkg.sv
// Shared definitions for the schoolRISCV data-memory controller:
// access size codes, FSM state encoding, requester (owner) encoding.
package sr_dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_WRITE  = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    // Sizes 10 and 11 both mean word.
    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] size);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sr_dmem_lane.sv
// Byte/half lane logic: extracts and extends a load value from a memory word
// and merges sub-word store data into it for read-modify-write.
module sr_dmem_lane
    import sr_dmem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = word[{addr, 3'b000} +: 8];
        half_v     = word[{addr[1], 4'b0000} +: 16];
        load_val   = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_val   = {{24{sign & byte_v[7]}}, byte_v};
                store_word = word;
                store_word[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val   = {{16{sign & half_v[15]}}, half_v};
                store_word = word;
                store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_val   = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/sr_dmem_ctrl.sv
// Multi-cycle data-memory controller: CPU + optional debug port onto one
// single-port SRAM. Debug port and round-robin arbiter exist only with SR_DMEM_DBG_EN.
module sr_dmem_ctrl
    import sr_dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic              cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d, dbg_ack_q, dbg_ack_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;

    logic              gnt_dbg;
    logic              sel_we, sel_sign, sel_err, fin;
    logic [ADDR_W+1:0] sel_addr;
    logic [1:0]        sel_size;
    logic [31:0]       sel_wdata, res, load_val, store_word;

`ifdef SR_DMEM_DBG_EN
    owner_t last_grant_q, last_grant_d;
    logic   unused_addr;

    // On a tie the requester that was not served last wins.
    assign gnt_dbg     = dbg_req & (~cpu_req | (last_grant_q == OWN_CPU));
    assign unused_addr = ^{cpu_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};
`else
    logic unused_dbg;

    assign gnt_dbg    = 1'b0;
    assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata, cpu_addr[31:ADDR_W+2]};
`endif

    always_comb begin
        sel_we    = gnt_dbg ? dbg_we : cpu_we;
        sel_size  = gnt_dbg ? SZ_WORD : cpu_size;
        sel_sign  = gnt_dbg ? 1'b0 : cpu_sign;
        sel_wdata = gnt_dbg ? dbg_wdata : cpu_wdata;
        sel_addr  = gnt_dbg ? {dbg_addr[ADDR_W+1:2], 2'b00} : cpu_addr[ADDR_W+1:0];
        sel_err   = ~gnt_dbg & is_misaligned(cpu_addr[1:0], cpu_size);
    end

    sr_dmem_lane u_lane (
        .word      (mem_rdata),
        .addr      (addr_q[1:0]),
        .size      (size_q),
        .sign      (sign_q),
        .wdata     (mem_wdata_q),
        .load_val  (load_val),
        .store_word(store_word)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        sign_d      = sign_q;
        err_d       = err_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = '0;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = '0;
        fin         = 1'b0;
        res         = '0;
`ifdef SR_DMEM_DBG_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req | gnt_dbg) begin
                    state_d     = ST_ISSUE;
                    owner_d     = gnt_dbg ? OWN_DBG : OWN_CPU;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    size_d      = sel_size;
                    sign_d      = sel_sign;
                    err_d       = sel_err;
                    mem_wdata_d = sel_wdata;
                    // Strobes are registered, so they are decided here for the ISSUE cycle.
                    mem_we_d    = ~sel_err & sel_we & sel_size[1];
                    mem_re_d    = ~sel_err & ~(sel_we & sel_size[1]);
`ifdef SR_DMEM_DBG_EN
                    last_grant_d = owner_d;
`endif
                end
            end
            ST_ISSUE: begin
                if (err_q || (we_q && size_q[1])) begin
                    state_d = ST_ACK;
                    fin     = 1'b1;
                end else begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (we_q) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = store_word;
                end else begin
                    state_d = ST_ACK;
                    fin     = 1'b1;
                    res     = load_val;
                end
            end
            ST_WRITE: begin
                state_d = ST_ACK;
                fin     = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            if (owner_q == OWN_DBG) begin
                dbg_ack_d   = 1'b1;
                dbg_rdata_d = res;
            end else begin
                cpu_ack_d   = 1'b1;
                cpu_err_d   = err_q;
                cpu_rdata_d = res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= SZ_WORD;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
`ifdef SR_DMEM_DBG_EN
            last_grant_q <= OWN_DBG;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef SR_DMEM_DBG_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_sr_dmem_ctrl.sv
// Directed bench for sr_dmem_ctrl with a behavioural 1-cycle-latency SRAM.
// Arbitration scenario runs only when SR_DMEM_DBG_EN is defined.
module tb_sr_dmem_ctrl;

    logic        clk, rst_n;
    logic        cpu_req, cpu_we, cpu_sign;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_size;
    logic        cpu_ack, cpu_stall, cpu_err;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [7:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;
    int dbg_acks = 0;

    logic [31:0] mem [0:255];

    sr_dmem_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    end

    // One CPU access: latency counts negedges from the IDLE cycle that sees the request.
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] sz, input logic sg,
                              output logic [31:0] rd, output logic er, output int lat,
                              output int nre, output int nwe);
        @(negedge clk);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_size = sz; cpu_sign = sg;
        cpu_req = 1'b1;
        lat = -1; nre = 0; nwe = 0; rd = '0; er = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_pending addr=%h got=%b want=1", addr, cpu_stall);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            nre += int'(mem_re);
            nwe += int'(mem_we);
            if (dbg_ack) dbg_acks++;
            if (cpu_ack) begin
                lat = k; rd = cpu_rdata; er = cpu_err;
                break;
            end
        end
        cpu_req = 1'b0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL ack_timeout addr=%h got=no ack want=ack within 10 cycles", addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 2'b10; cpu_sign = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_err, cpu_stall, dbg_ack, mem_re, mem_we} !== 6'b0 ||
            cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=ack%b err%b stall%b dack%b re%b we%b rd=%h drd=%h want=all 0",
                     cpu_ack, cpu_err, cpu_stall, dbg_ack, mem_re, mem_we, cpu_rdata, dbg_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_store();
        logic [31:0] rd; logic er; int lat, nre, nwe;
        cpu_access(1'b1, 32'h40, 32'h8899AABB, 2'b10, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 2 || nre != 0 || nwe != 1 || er !== 1'b0 || mem[8'h10] !== 32'h8899AABB) begin
            errors++;
            $display("FAIL sw_0x40 got=lat%0d re%0d we%0d err%b mem=%h want=lat2 re0 we1 err0 mem=8899aabb",
                     lat, nre, nwe, er, mem[8'h10]);
        end
        cpu_access(1'b1, 32'h44, 32'hDEADBEEF, 2'b11, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 2 || nwe != 1 || mem[8'h11] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_0x44 got=lat%0d we%0d mem=%h want=lat2 we1 mem=deadbeef", lat, nwe, mem[8'h11]);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic er; int lat, nre, nwe;
        logic [31:0] addrs [6] = '{32'h41, 32'h41, 32'h42, 32'h40, 32'h43, 32'h444};
        logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        logic        signs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] exps  [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB,
                                  32'hFFFFFF88, 32'hDEADBEEF};
        for (int i = 0; i < 6; i++) begin
            cpu_access(1'b0, addrs[i], 32'h0, sizes[i], signs[i], rd, er, lat, nre, nwe);
            checks++;
            if (rd !== exps[i] || lat != 3 || nre != 1 || nwe != 0 || er !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d addr=%h got=rd%h lat%0d re%0d we%0d err%b want=rd%h lat3 re1 we0 err0",
                         i, addrs[i], rd, lat, nre, nwe, er, exps[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd; logic er; int lat, nre, nwe;
        cpu_access(1'b1, 32'h42, 32'h00001234, 2'b01, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 4 || nre != 1 || nwe != 1 || mem[8'h10] !== 32'h1234AABB) begin
            errors++;
            $display("FAIL sh_0x42 got=lat%0d re%0d we%0d mem=%h want=lat4 re1 we1 mem=1234aabb",
                     lat, nre, nwe, mem[8'h10]);
        end
        cpu_access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (rd !== 32'h1234AABB) begin
            errors++;
            $display("FAIL lw_after_sh got=%h want=1234aabb", rd);
        end
        cpu_access(1'b1, 32'h41, 32'hFFFFFF7F, 2'b00, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 4 || mem[8'h10] !== 32'h12347FBB) begin
            errors++;
            $display("FAIL sb_0x41 got=lat%0d mem=%h want=lat4 mem=12347fbb", lat, mem[8'h10]);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat, nre, nwe;
        cpu_access(1'b0, 32'h42, 32'h0, 2'b10, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 2 || er !== 1'b1 || rd !== 32'h0 || nre != 0 || nwe != 0) begin
            errors++;
            $display("FAIL lw_misalign got=lat%0d err%b rd%h re%0d we%0d want=lat2 err1 rd0 re0 we0",
                     lat, er, rd, nre, nwe);
        end
        cpu_access(1'b1, 32'h41, 32'h0000BEEF, 2'b01, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 2 || er !== 1'b1 || nwe != 0 || mem[8'h10] !== 32'h12347FBB) begin
            errors++;
            $display("FAIL sh_misalign got=lat%0d err%b we%0d mem=%h want=lat2 err1 we0 mem=12347fbb",
                     lat, er, nwe, mem[8'h10]);
        end
    endtask

    task automatic test_back_to_back();
        int a1 = -1, a2 = -1;
        @(negedge clk);
        cpu_we = 0; cpu_addr = 32'h40; cpu_size = 2'b10; cpu_sign = 0; cpu_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (a1 < 0) a1 = k;
                else if (a2 < 0) begin a2 = k; cpu_req = 1'b0; end
            end
        end
        cpu_req = 1'b0;
        checks++;
        if (a1 != 3 || a2 != 7) begin
            errors++;
            $display("FAIL back_to_back got=acks at %0d,%0d want=3,7", a1, a2);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic er; int lat, nre, nwe;
        @(negedge clk);
        cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h55; cpu_size = 2'b00; cpu_sign = 0;
        cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rmw_write_phase got=mem_we %b want=1", mem_we);
        end
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL async_abort got=we%b ack%b want=we0 ack0", mem_we, cpu_ack);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem[8'h10] !== 32'h12347FBB || cpu_ack !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write got=mem%h ack%b re%b want=mem12347fbb ack0 re0",
                     mem[8'h10], cpu_ack, mem_re);
        end
        cpu_access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 3 || rd !== 32'h12347FBB) begin
            errors++;
            $display("FAIL post_reset_lw got=lat%0d rd%h want=lat3 rd12347fbb", lat, rd);
        end
    endtask

`ifdef SR_DMEM_DBG_EN
    task automatic test_arbitration();
        int order [8];
        int n = 0;
        logic [31:0] drd = '0;
        rst_n = 1'b0;
        cpu_we = 0; cpu_addr = 32'h40; cpu_size = 2'b10; cpu_sign = 0; cpu_req = 1'b1;
        dbg_we = 0; dbg_addr = 32'h46; dbg_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (cpu_ack && n < 8) begin order[n] = 0; n++; end
            if (dbg_ack && n < 8) begin order[n] = 1; n++; drd = dbg_rdata; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++;
        if (n != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            errors++;
            $display("FAIL rr_order got=n%0d %0d%0d%0d%0d want=n4 0101", n, order[0], order[1], order[2], order[3]);
        end
        checks++;
        if (drd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL dbg_rdata got=%h want=deadbeef", drd);
        end
    endtask
`else
    task automatic test_dbg_disabled();
        logic [31:0] rd; logic er; int lat, nre, nwe;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h0;
        dbg_acks = 0;
        cpu_access(1'b0, 32'h44, 32'h0, 2'b10, 1'b0, rd, er, lat, nre, nwe);
        checks++;
        if (lat != 3 || rd !== 32'hDEADBEEF || dbg_acks != 0 || dbg_rdata !== 32'h0 ||
            mem[8'h10] !== 32'h12347FBB) begin
            errors++;
            $display("FAIL dbg_ignored got=lat%0d rd%h dacks%0d drd%h mem%h want=lat3 rddeadbeef dacks0 drd0 mem12347fbb",
                     lat, rd, dbg_acks, dbg_rdata, mem[8'h10]);
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_word_store();
        test_load_ext();
        test_subword_store();
        test_misalign();
        test_back_to_back();
        test_reset_mid_write();
`ifdef SR_DMEM_DBG_EN
        test_arbitration();
`else
        test_dbg_disabled();
`endif
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL re_we_exclusive got=%0d overlaps want=0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
